// File: rtl/ballot_ctrl.sv
// ballot_ctrl: debounced one-vote-per-ballot front end for the four-candidate tally.
module ballot_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        arm,
    input  logic [3:0]  btn,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        ready,
    output logic        multi_err,
    output logic [20:0] ballots
);
    typedef enum logic [2:0] {IDLE, ARMED, DEBOUNCE, CAST, RELEASE} state_t;
    localparam logic [7:0] LAST = 8'(DEBOUNCE_CYCLES - 1);
    state_t      r_state, w_next;
    logic [3:0]  r_sel, r_vote;
    logic [7:0]  r_cnt;
    logic [20:0] r_ballots;
    logic        r_multi, w_multi, w_one;
    assign w_multi = (btn & (btn - 4'd1)) != 4'd0;
    assign w_one   = btn != 4'd0 && !w_multi;
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end
    always_comb begin
        w_next = IDLE;
        case (r_state)
            IDLE:     w_next = (arm && btn == 4'd0) ? ARMED : IDLE;
            ARMED:    w_next = w_one ? DEBOUNCE : ARMED;
            DEBOUNCE: w_next = btn != r_sel ? ARMED : (r_cnt == LAST ? CAST : DEBOUNCE);
            CAST:     w_next = RELEASE;
            RELEASE:  w_next = btn == 4'd0 ? IDLE : RELEASE;
            default:  w_next = IDLE;
        endcase
    end
    // Vote pulse is registered on the edge entering CAST so it spans exactly the CAST cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel     <= 4'd0;
            r_cnt     <= 8'd0;
            r_ballots <= 21'd0;
            r_vote    <= 4'd0;
            r_multi   <= 1'b0;
        end else begin
            r_multi <= r_state == ARMED && w_multi;
            r_vote  <= w_next == CAST ? r_sel : 4'd0;
            if (r_state == ARMED && w_one) begin
                r_sel <= btn;
                r_cnt <= 8'd1;
            end else if (r_state == DEBOUNCE) begin
                if (btn != r_sel) begin
                    r_sel <= 4'd0;
                    r_cnt <= 8'd0;
                end else if (r_cnt != LAST) begin
                    r_cnt <= r_cnt + 8'd1;
                end
            end
            if (r_state == CAST && r_ballots != '1) r_ballots <= r_ballots + 21'd1;
        end
    end
    always_comb begin
        {d, c, b, a} = r_vote;
        ready        = r_state == ARMED;
        multi_err    = r_multi;
        ballots      = r_ballots;
    end
endmodule

// File: tb/tb_ballot_ctrl.sv
// tb_ballot_ctrl: directed stimulus with a queue scoreboard checked by a negedge monitor.
module tb_ballot_ctrl;
    localparam int N = 4;
    logic        clk = 1'b0, rst = 1'b1, arm = 1'b0;
    logic [3:0]  btn = 4'd0;
    logic        a, b, c, d, ready, multi_err;
    logic [20:0] ballots;
    logic [20:0] exp_bal = 21'd0;
    int          checks = 0, errors = 0, cyc = 0;
    typedef struct {logic [3:0] v; int cyc; logic [20:0] bal;} vote_t;
    vote_t vq[$];
    int    mq[$];

    ballot_ctrl #(.DEBOUNCE_CYCLES(N)) dut (
        .clk(clk), .rst(rst), .arm(arm), .btn(btn),
        .a(a), .b(b), .c(c), .d(d),
        .ready(ready), .multi_err(multi_err), .ballots(ballots)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_arm;
        arm = 1'b1;
        step;
        arm = 1'b0;
        check("ready_armed", 32'(ready), 32'd1);
    endtask

    task automatic vote(input logic [3:0] v);
        vq.push_back('{v, cyc + N, exp_bal});
        btn = v;
        repeat (N) step;
        btn = 4'd0;
        repeat (2) step;
        if (exp_bal != '1) exp_bal++;
        check("ballots_after_vote", 32'(ballots), 32'(exp_bal));
    endtask

    // Monitor: every pulse or error flag the DUT shows must match the head of a queue.
    always @(negedge clk) begin
        vote_t e;
        int    mc;
        if ({d, c, b, a} != 4'd0) begin
            checks++;
            if (vq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse got %b at cyc %0d", {d, c, b, a}, cyc);
            end else begin
                e = vq.pop_front();
                if ({d, c, b, a} !== e.v || cyc != e.cyc || ballots !== e.bal) begin
                    errors++;
                    $display("FAIL pulse got v=%b cyc=%0d bal=%0h expected v=%b cyc=%0d bal=%0h",
                             {d, c, b, a}, cyc, ballots, e.v, e.cyc, e.bal);
                end
            end
        end
        if (multi_err === 1'b1) begin
            checks++;
            if (mq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_multi_err at cyc %0d", cyc);
            end else begin
                mc = mq.pop_front();
                if (cyc != mc) begin
                    errors++;
                    $display("FAIL multi_err got cyc %0d expected cyc %0d", cyc, mc);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [6:0] pat;
        repeat (2) step;
        rst = 1'b0;
        check("reset_ready", 32'(ready), 32'd0);
        check("reset_ballots", 32'(ballots), 32'd0);
        check("reset_pulses", 32'({d, c, b, a}), 32'd0);
        check("reset_multi", 32'(multi_err), 32'd0);
        // Basic vote for B
        do_arm;
        vote(4'b0010);
        check("idle_not_ready", 32'(ready), 32'd0);
        // Bounce on A: only the final run of four highs counts
        do_arm;
        pat = 7'b1111011;
        for (int i = 0; i < 7; i++) begin
            if (i == 3) vq.push_back('{4'b0001, cyc + N, exp_bal});
            btn = {3'b000, pat[i]};
            step;
        end
        btn = 4'd0;
        repeat (2) step;
        exp_bal++;
        check("ballots_bounce", 32'(ballots), 32'(exp_bal));
        // Multi-press then a clean D
        do_arm;
        repeat (3) begin
            mq.push_back(cyc + 1);
            btn = 4'b0101;
            step;
        end
        btn = 4'd0;
        step;
        check("multi_stays_armed", 32'(ready), 32'd1);
        vote(4'b1000);
        // Held C with arm held: one vote only, pre-held press blocked in IDLE
        do_arm;
        vq.push_back('{4'b0100, cyc + N, exp_bal});
        btn = 4'b0100;
        arm = 1'b1;
        repeat (N + 20) step;
        exp_bal++;
        check("ballots_held", 32'(ballots), 32'(exp_bal));
        check("held_not_ready", 32'(ready), 32'd0);
        btn = 4'd0;
        step;
        btn = 4'b0100;
        repeat (3) step;
        check("preheld_blocked", 32'(ready), 32'd0);
        btn = 4'd0;
        step;
        arm = 1'b0;
        check("rearm_ready", 32'(ready), 32'd1);
        // Reset on the edge that would enter CAST
        btn = 4'b0001;
        repeat (N - 1) step;
        rst = 1'b1;
        step;
        rst = 1'b0;
        btn = 4'd0;
        exp_bal = 21'd0;
        check("midrst_ready", 32'(ready), 32'd0);
        check("midrst_pulses", 32'({d, c, b, a}), 32'd0);
        check("midrst_ballots", 32'(ballots), 32'd0);
        step;
        // Saturation via backdoor
        force dut.r_ballots = '1;
        step;
        release dut.r_ballots;
        step;
        exp_bal = '1;
        check("sat_preload", 32'(ballots), 32'(exp_bal));
        do_arm;
        vote(4'b0001);
        do_arm;
        vote(4'b0100);
        repeat (3) step;
        check("pending_votes", 32'(vq.size()), 32'd0);
        check("pending_multi", 32'(mq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
